// File: rtl/audio_fetch_arbiter.sv
// audio_fetch_arbiter
// Round-robin arbiter that shares one AXI-Lite read master among the
// per-channel sample fetch units. One read is in flight at a time; the
// result returns to the granted channel with a one-cycle strobe.
module audio_fetch_arbiter #(
    parameter int CHANNELS   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            req_valid,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] req_addr,
    output logic [CHANNELS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic                           resp_err,
    output logic                           busy,
    output logic [ADDR_WIDTH-1:0]          m_axil_araddr,
    output logic [2:0]                     m_axil_arprot,
    output logic                           m_axil_arvalid,
    input  logic                           m_axil_arready,
    input  logic [DATA_WIDTH-1:0]          m_axil_rdata,
    input  logic [1:0]                     m_axil_rresp,
    input  logic                           m_axil_rvalid,
    output logic                           m_axil_rready
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant;

    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       sel_next;
    logic [ADDR_WIDTH-1:0]  addr_arr [CHANNELS];

    // Reads are unprivileged, secure, data accesses.
    assign m_axil_arprot = 3'b000;

    function automatic logic [CHANNELS-1:0] one_hot(input logic [IDX_W-1:0] idx);
        logic [CHANNELS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Unpack the flat request address bus into one word per channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
    always_comb begin
        logic             found_hi;
        logic [IDX_W-1:0] idx_hi;
        logic             found_any;
        logic [IDX_W-1:0] idx_any;
        found_hi  = 1'b0;
        idx_hi    = '0;
        found_any = 1'b0;
        idx_any   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found_any = 1'b1;
                idx_any   = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr) begin
                    found_hi = 1'b1;
                    idx_hi   = IDX_W'(i);
                end
            end
        end
        sel_found = found_any;
        sel_idx   = found_hi ? idx_hi : idx_any;
        sel_next  = (sel_idx == IDX_W'(CHANNELS - 1)) ? '0 : sel_idx + 1'b1;
    end

    // Transaction FSM: grant, address phase, data phase, response strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant          <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            m_axil_araddr  <= '0;
            resp_valid     <= '0;
            resp_data      <= '0;
            resp_err       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant          <= sel_idx;
                        m_axil_araddr  <= addr_arr[sel_idx];
                        m_axil_arvalid <= 1'b1;
                        rr_ptr         <= sel_next;
                        busy           <= 1'b1;
                        state          <= ADDR;
                    end
                end
                ADDR: begin
                    // arvalid/araddr stay put until the slave accepts them.
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= DATA;
                    end
                end
                DATA: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        resp_data     <= m_axil_rdata;
                        resp_err      <= (m_axil_rresp != 2'b00);
                        resp_valid    <= one_hot(grant);
                        state         <= RESP;
                    end
                end
                RESP: begin
                    // Strobe lasts one cycle; data and error hold until the next response.
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    m_axil_arvalid <= 1'b0;
                    m_axil_rready  <= 1'b0;
                    resp_valid     <= '0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_fetch_arbiter.sv
// Testbench for audio_fetch_arbiter: AXI-Lite slave model with programmable
// delays, and a scoreboard of expected responses in grant order.
module tb_audio_fetch_arbiter;

    localparam int CH = 8;
    localparam int AW = 32;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic [CH-1:0]     req_valid;
    logic [CH*AW-1:0]  req_addr;
    logic [CH-1:0]     resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_err;
    logic              busy;
    logic [AW-1:0]     m_axil_araddr;
    logic [2:0]        m_axil_arprot;
    logic              m_axil_arvalid;
    logic              m_axil_arready;
    logic [DW-1:0]     m_axil_rdata;
    logic [1:0]        m_axil_rresp;
    logic              m_axil_rvalid;
    logic              m_axil_rready;

    audio_fetch_arbiter #(
        .CHANNELS  (CH),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .busy          (busy),
        .m_axil_araddr (m_axil_araddr),
        .m_axil_arprot (m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid),
        .m_axil_arready(m_axil_arready),
        .m_axil_rdata  (m_axil_rdata),
        .m_axil_rresp  (m_axil_rresp),
        .m_axil_rvalid (m_axil_rvalid),
        .m_axil_rready (m_axil_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] oh;
        logic [DW-1:0] data;
        logic          err;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Memory contents and response codes seen by the slave model.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'h100) return 16'hBEEF;
        if (a == 32'h200) return 16'h1234;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [AW-1:0] a);
        return (a == 32'h200) ? 2'b10 : 2'b00;
    endfunction

    task automatic push_exp(input int ch, input logic [AW-1:0] a);
        exp_t e;
        e.oh   = 8'b1 << ch;
        e.data = mem_word(a);
        e.err  = (mem_resp(a) != 2'b00);
        e.addr = a;
        sb_q.push_back(e);
    endtask

    task automatic set_addr(input int ch, input logic [AW-1:0] a);
        req_addr[ch*AW +: AW] = a;
    endtask

    // Slave model, protocol monitor and scoreboard.
    int            ar_delay = 0;
    int            r_delay  = 0;
    int            ar_cnt, r_cnt;
    bit            pend, ar_prev, r_prev;
    logic [AW-1:0] ar_addr_prev, pend_addr;
    int            viol_stable  = 0;
    int            viol_overlap = 0;

    always @(negedge clk) begin
        if (rst) begin
            pend           = 1'b0;
            ar_prev        = 1'b0;
            r_prev         = 1'b0;
            ar_cnt         = 0;
            r_cnt          = 0;
            m_axil_arready = 1'b0;
            m_axil_rvalid  = 1'b0;
            m_axil_rdata   = '0;
            m_axil_rresp   = 2'b00;
        end else begin
            if (ar_prev && !m_axil_arready &&
                (!m_axil_arvalid || m_axil_araddr != ar_addr_prev)) viol_stable++;
            if (m_axil_arvalid && m_axil_rready) viol_overlap++;
            if (m_axil_arready && ar_prev) begin
                pend      = 1'b1;
                pend_addr = ar_addr_prev;
                ar_cnt    = 0;
                r_cnt     = 0;
            end
            if (m_axil_rvalid && r_prev) pend = 1'b0;
            if (|resp_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_empty", 64'(resp_valid), 64'(0));
                end else begin
                    sb_e = sb_q.pop_front();
                    check_eq("resp_ch",   64'(resp_valid), 64'(sb_e.oh));
                    check_eq("resp_data", 64'(resp_data),  64'(sb_e.data));
                    check_eq("resp_err",  64'(resp_err),   64'(sb_e.err));
                    check_eq("ar_addr",   64'(pend_addr),  64'(sb_e.addr));
                end
            end
            m_axil_arready = 1'b0;
            m_axil_rvalid  = 1'b0;
            m_axil_rdata   = '0;
            m_axil_rresp   = 2'b00;
            if (!pend && m_axil_arvalid) begin
                if (ar_cnt >= ar_delay) m_axil_arready = 1'b1;
                else ar_cnt++;
            end
            if (pend && m_axil_rready) begin
                if (r_cnt >= r_delay) begin
                    m_axil_rvalid = 1'b1;
                    m_axil_rdata  = mem_word(pend_addr);
                    m_axil_rresp  = mem_resp(pend_addr);
                end else begin
                    r_cnt++;
                end
            end
            ar_prev      = m_axil_arvalid;
            ar_addr_prev = m_axil_araddr;
            r_prev       = m_axil_rready;
        end
    end

    // Waits for n response strobes (bounded), optionally dropping served requests.
    task automatic run_resps(input int n, input bit drop, input int max_cyc,
                             output int cyc, output int busy_lo,
                             output int arv_cyc, output int rr_cyc);
        int seen;
        seen = 0; cyc = 0; busy_lo = 0; arv_cyc = 0; rr_cyc = 0;
        while (seen < n && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_lo++;
            if (m_axil_arvalid) arv_cyc++;
            if (m_axil_rready) rr_cyc++;
            if (|resp_valid) begin
                seen++;
                if (drop) req_valid = req_valid & ~resp_valid;
            end
        end
        check_eq("resp_count", 64'(seen), 64'(n));
    endtask

    int cyc, busy_lo, arv_cyc, rr_cyc, w;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_arvalid", 64'(m_axil_arvalid), 64'(0));
        check_eq("rst_rready",  64'(m_axil_rready),  64'(0));
        check_eq("rst_araddr",  64'(m_axil_araddr),  64'(0));
        check_eq("rst_resp_v",  64'(resp_valid),     64'(0));
        check_eq("rst_resp_d",  64'(resp_data),      64'(0));
        check_eq("rst_resp_e",  64'(resp_err),       64'(0));
        check_eq("rst_busy",    64'(busy),           64'(0));
        check_eq("arprot",      64'(m_axil_arprot),  64'(0));

        // Round-robin: all channels requesting from reset
        for (int i = 0; i < CH; i++) set_addr(i, 32'h1000 + 32'(4 * i));
        req_valid = 8'hFF;
        for (int i = 0; i < CH; i++) push_exp(i, 32'h1000 + 32'(4 * i));
        for (int i = 0; i < 4; i++) push_exp(i, 32'h1000 + 32'(4 * i));
        @(negedge clk);
        rst = 1'b0;
        run_resps(12, 1'b0, 200, cyc, busy_lo, arv_cyc, rr_cyc);
        // Now rr_ptr points at 4: only channels 3 and 5 keep requesting
        req_valid = 8'b0010_1000;
        push_exp(5, 32'h1014);
        push_exp(3, 32'h100C);
        push_exp(5, 32'h1014);
        run_resps(3, 1'b0, 60, cyc, busy_lo, arv_cyc, rr_cyc);
        req_valid = '0;
        repeat (3) @(negedge clk);
        check_eq("rr_idle_busy", 64'(busy), 64'(0));

        // Single request with immediate slave
        set_addr(2, 32'h100);
        req_valid = 8'b0000_0100;
        push_exp(2, 32'h100);
        run_resps(1, 1'b1, 20, cyc, busy_lo, arv_cyc, rr_cyc);
        check_eq("single_lat",   64'(cyc),     64'(3));
        check_eq("single_arv",   64'(arv_cyc), 64'(1));
        check_eq("single_rr",    64'(rr_cyc),  64'(1));
        check_eq("single_busy",  64'(busy_lo), 64'(0));
        @(negedge clk);
        check_eq("single_pulse", 64'(resp_valid), 64'(0));
        check_eq("single_idle",  64'(busy),       64'(0));
        check_eq("single_hold",  64'(resp_data),  64'(16'hBEEF));

        // Backpressure on both channels
        ar_delay = 5;
        r_delay  = 7;
        set_addr(6, 32'h300);
        req_valid = 8'b0100_0000;
        push_exp(6, 32'h300);
        run_resps(1, 1'b1, 60, cyc, busy_lo, arv_cyc, rr_cyc);
        check_eq("bp_arv_cyc", 64'(arv_cyc), 64'(6));
        check_eq("bp_rr_cyc",  64'(rr_cyc),  64'(8));
        check_eq("bp_busy",    64'(busy_lo), 64'(0));
        ar_delay = 0;
        r_delay  = 0;
        repeat (3) @(negedge clk);

        // Error response
        set_addr(1, 32'h200);
        req_valid = 8'b0000_0010;
        push_exp(1, 32'h200);
        run_resps(1, 1'b1, 20, cyc, busy_lo, arv_cyc, rr_cyc);
        @(negedge clk);
        check_eq("err_idle", 64'(busy),     64'(0));
        check_eq("err_hold", 64'(resp_err), 64'(1));

        // Address change and request drop while in DATA
        r_delay = 3;
        set_addr(4, 32'h400);
        req_valid = 8'b0001_0000;
        push_exp(4, 32'h400);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!m_axil_rready && w < 20);
        check_eq("mid_data_reached", 64'(m_axil_rready), 64'(1));
        set_addr(4, 32'h500);
        req_valid = '0;
        run_resps(1, 1'b0, 20, cyc, busy_lo, arv_cyc, rr_cyc);
        r_delay = 0;
        repeat (3) @(negedge clk);
        check_eq("mid_no_regrant", 64'(busy), 64'(0));

        // Reset while in ADDR
        ar_delay = 10;
        set_addr(2, 32'h20);
        set_addr(6, 32'h60);
        req_valid = 8'b0100_0100;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!m_axil_arvalid && w < 20);
        check_eq("rst_pre_addr", 64'(m_axil_araddr), 64'(32'h60));
        #2 rst = 1'b1;
        #1;
        check_eq("async_arvalid", 64'(m_axil_arvalid), 64'(0));
        check_eq("async_busy",    64'(busy),           64'(0));
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        ar_delay = 0;
        push_exp(2, 32'h20);
        push_exp(6, 32'h60);
        run_resps(2, 1'b1, 40, cyc, busy_lo, arv_cyc, rr_cyc);
        repeat (3) @(negedge clk);

        check_eq("sb_left",      64'(sb_q.size()),  64'(0));
        check_eq("ar_stable",    64'(viol_stable),  64'(0));
        check_eq("ar_r_overlap", 64'(viol_overlap), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
